// File: rtl/acc_send_ctrl.sv
// acc_send_ctrl: send-side controller that streams accumulator contents to the
// next PE as multi-lane beats. It gates each beat on the receive-side fill
// counter, honours downstream backpressure, masks lanes past the end of the
// accumulator, and latches one start request so passes can run back to back.
module acc_send_ctrl #(
    parameter int ACC_SIZE   = 9,
    parameter int ACC_ADDR_W = 4,
    parameter int LANES      = 4,
    parameter int IDX_W      = $clog2(ACC_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_done_in,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  out_ready,
    output logic                  acc_valid_out,
    output logic [ACC_ADDR_W-1:0] acc_addr_out,
    output logic [LANES-1:0]      acc_lane_mask,
    output logic                  idx_init,
    output logic                  busy
);

    // Wide enough that addr + LANES and idx both fit without wrapping.
    localparam int WIDE_BASE = (IDX_W > ACC_ADDR_W) ? IDX_W : ACC_ADDR_W;
    localparam int SUM_W     = WIDE_BASE + $clog2(LANES + 1) + 1;

    localparam logic [SUM_W-1:0]      SIZE_WIDE  = SUM_W'(ACC_SIZE);
    localparam logic [SUM_W-1:0]      LANES_WIDE = SUM_W'(LANES);
    localparam logic [ACC_ADDR_W-1:0] ADDR_STEP  = ACC_ADDR_W'(LANES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_ADDR_W-1:0]   addr_q,  addr_d;
    logic                    pend_q,  pend_d;

    logic [SUM_W-1:0]        addr_wide_s;
    logic [SUM_W-1:0]        addr_plus_s;
    logic [SUM_W-1:0]        end_a_s;
    logic                    ready_beat_s;
    logic                    last_s;
    logic                    fire_s;
    logic [LANES-1:0]        lane_in_s;

    // Beat geometry: where the beat ends, whether its data is all written,
    // whether it is the final beat, and which lanes fall inside the array.
    always_comb begin
        addr_wide_s  = SUM_W'(addr_q);
        addr_plus_s  = addr_wide_s + LANES_WIDE;
        if (addr_plus_s < SIZE_WIDE) begin
            end_a_s = addr_plus_s;
        end else begin
            end_a_s = SIZE_WIDE;
        end
        ready_beat_s = (SUM_W'(idx) >= end_a_s);
        last_s       = (addr_plus_s >= SIZE_WIDE);
        lane_in_s    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_in_s[i] = ((addr_wide_s + SUM_W'(i)) < SIZE_WIDE);
        end
    end

    // Next-state and output decode for the IDLE/SEND controller.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        pend_d        = pend_q;
        acc_valid_out = 1'b0;
        acc_lane_mask = '0;
        idx_init      = 1'b0;
        busy          = 1'b0;
        fire_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_done_in || pend_q) begin
                    state_d = SEND;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                busy          = 1'b1;
                acc_valid_out = ready_beat_s;
                if (ready_beat_s) begin
                    acc_lane_mask = lane_in_s;
                end else begin
                    acc_lane_mask = '0;
                end
                fire_s = ready_beat_s && out_ready;
                if (fire_s && last_s) begin
                    // Pass complete: rewind and tell the receive side to refill.
                    addr_d   = '0;
                    idx_init = 1'b1;
                    if (pend_q || acc_done_in) begin
                        state_d = SEND;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (fire_s) begin
                        addr_d = addr_q + ADDR_STEP;
                    end else begin
                        addr_d = addr_q;
                    end
                    // A request during a pass is remembered once; extras are dropped.
                    if (acc_done_in) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign acc_addr_out = addr_q;

    // State registers with synchronous active-low reset; a reset abandons any pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_acc_send_ctrl.sv
// Scoreboard bench for acc_send_ctrl: directed stimulus pushes the expected
// beats into per-instance queues; a negedge monitor pops and compares every
// accepted beat. Instance A uses ACC_SIZE=9, instance B ACC_SIZE=3 (single beat).
module tb_acc_send_ctrl;

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] mask;
        logic       init;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       done_a, rdy_a, valid_a, init_a, busy_a;
    logic [3:0] idx_a;
    logic [3:0] addr_a, mask_a;

    logic       done_b, rdy_b, valid_b, init_b, busy_b;
    logic [1:0] idx_b;
    logic [3:0] addr_b, mask_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int total;
    int bad;
    int fires_a;
    int fires_b;

    acc_send_ctrl #(.ACC_SIZE(9), .ACC_ADDR_W(4), .LANES(4)) dut_a (
        .clk(clk), .rst(rst), .acc_done_in(done_a), .idx(idx_a),
        .out_ready(rdy_a), .acc_valid_out(valid_a), .acc_addr_out(addr_a),
        .acc_lane_mask(mask_a), .idx_init(init_a), .busy(busy_a)
    );

    acc_send_ctrl #(.ACC_SIZE(3), .ACC_ADDR_W(4), .LANES(4)) dut_b (
        .clk(clk), .rst(rst), .acc_done_in(done_b), .idx(idx_b),
        .out_ready(rdy_b), .acc_valid_out(valid_b), .acc_addr_out(addr_b),
        .acc_lane_mask(mask_b), .idx_init(init_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int a, input int m, input int i);
        exp_t e;
        e.addr = 4'(a);
        e.mask = 4'(m);
        e.init = 1'(i);
        q_a.push_back(e);
    endtask

    // Monitor: compare every accepted beat against the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (valid_a && rdy_a) begin
            fires_a++;
            check("a_beat_expected", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_addr", int'(addr_a), int'(e.addr));
                check("a_mask", int'(mask_a), int'(e.mask));
                check("a_idx_init", int'(init_a), int'(e.init));
            end
        end
        check("a_init_without_fire", int'(init_a & ~(valid_a & rdy_a)), 0);
        if (valid_b && rdy_b) begin
            fires_b++;
            check("b_beat_expected", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_addr", int'(addr_b), int'(e.addr));
                check("b_mask", int'(mask_b), int'(e.mask));
                check("b_idx_init", int'(init_b), int'(e.init));
            end
        end
        check("b_init_without_fire", int'(init_b & ~(valid_b & rdy_b)), 0);
    end

    initial begin
        int m_addr;
        int m_active;
        int exp_v;
        int lim;
        int f0;
        exp_t eb;

        total = 0; bad = 0; fires_a = 0; fires_b = 0;
        rst = 1'b0;
        done_a = 1'b0; rdy_a = 1'b1; idx_a = 4'd0;
        done_b = 1'b0; rdy_b = 1'b1; idx_b = 2'd0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_addr", int'(addr_a), 0);
        check("rst_mask", int'(mask_a), 0);
        check("rst_init", int'(init_a), 0);
        tick();
        rst = 1'b1;
        tick();

        // 1: single pass, full fill, always ready -> three consecutive beats
        idx_a = 4'd9;
        push_a(0, 4'b1111, 0); push_a(4, 4'b1111, 0); push_a(8, 4'b0001, 1);
        f0 = fires_a;
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        check("p1_beats", fires_a - f0, 3);
        check("p1_idle_busy", int'(busy_a), 0);
        check("p1_idle_valid", int'(valid_a), 0);
        tick();

        // 2: fill-gated pass, idx ramps one per cycle from 0
        idx_a = 4'd0;
        push_a(0, 4'b1111, 0); push_a(4, 4'b1111, 0); push_a(8, 4'b0001, 1);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        m_addr = 0; m_active = 1;
        for (int c = 0; c < 20 && m_active == 1; c++) begin
            @(negedge clk);
            lim = (m_addr + 4 < 9) ? m_addr + 4 : 9;
            exp_v = (int'(idx_a) >= lim) ? 1 : 0;
            check("p2_valid_gate", int'(valid_a), exp_v);
            check("p2_addr_hold", int'(addr_a), m_addr);
            if (exp_v == 1) begin
                if (m_addr + 4 >= 9) m_active = 0;
                else m_addr = m_addr + 4;
            end
            tick();
            if (idx_a < 4'd9) idx_a = idx_a + 4'd1;
        end
        check("p2_completed", m_active, 0);
        @(negedge clk);
        check("p2_idle_busy", int'(busy_a), 0);
        tick();

        // 3: backpressure at the addr-4 beat for five cycles
        idx_a = 4'd9;
        push_a(0, 4'b1111, 0); push_a(4, 4'b1111, 0); push_a(8, 4'b0001, 1);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        tick();
        rdy_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("p3_stall_valid", int'(valid_a), 1);
            check("p3_stall_addr", int'(addr_a), 4);
            check("p3_stall_mask", int'(mask_a), 15);
            tick();
        end
        rdy_a = 1'b1;
        tick();
        @(negedge clk);
        check("p3_addr_after_release", int'(addr_a), 8);
        tick(); tick();
        @(negedge clk);
        check("p3_idle_busy", int'(busy_a), 0);
        tick();

        // 4: pending request during the addr-4 beat -> back-to-back second pass
        idx_a = 4'd9;
        push_a(0, 4'b1111, 0); push_a(4, 4'b1111, 0); push_a(8, 4'b0001, 1);
        push_a(0, 4'b1111, 0); push_a(4, 4'b1111, 0); push_a(8, 4'b0001, 1);
        f0 = fires_a;
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        tick();
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        tick();
        idx_a = 4'd0;
        @(negedge clk);
        check("p4_b2b_busy", int'(busy_a), 1);
        check("p4_b2b_addr", int'(addr_a), 0);
        check("p4_b2b_valid", int'(valid_a), 0);
        tick();
        idx_a = 4'd9;
        tick(); tick(); tick(); tick(); tick();
        @(negedge clk);
        check("p4_beats", fires_a - f0, 6);
        check("p4_idle_busy", int'(busy_a), 0);
        tick();

        // 5: reset mid-pass with a request pending
        idx_a = 4'd9;
        push_a(0, 4'b1111, 0);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        tick();
        done_a = 1'b1;
        rdy_a = 1'b0;
        tick();
        done_a = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rdy_a = 1'b1;
        @(negedge clk);
        check("p5_busy", int'(busy_a), 0);
        check("p5_valid", int'(valid_a), 0);
        check("p5_addr", int'(addr_a), 0);
        check("p5_mask", int'(mask_a), 0);
        check("p5_init", int'(init_a), 0);
        tick(); tick();
        @(negedge clk);
        check("p5_pending_lost", int'(busy_a), 0);
        tick();

        // 6: degenerate size (3 entries, 4 lanes) -> one beat, mask 0111
        idx_b = 2'd3;
        eb.addr = 4'd0; eb.mask = 4'b0111; eb.init = 1'b1;
        q_b.push_back(eb);
        f0 = fires_b;
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("p6_beats", fires_b - f0, 1);
        check("p6_idle_busy", int'(busy_b), 0);
        tick();

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
